fetch_stage: RTL and testbench

//  Instruction-fetch stage: the producer end of the fetch->decode interface (instruction/immediate pair).

---
 rtl/isa_pkg.sv | 24 ++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// ISA definitions shared by fetch, decode and control: opcode constants,
// the immediate-class predicate and the fetch FSM state encoding.
package isa_pkg;

  localparam logic [4:0] OP_NOT  = 5'b00011;
  localparam logic [4:0] OP_IADD = 5'b01011;
  localparam logic [4:0] OP_LDM  = 5'b10100;
  localparam logic [4:0] OP_LDD  = 5'b10101;
  localparam logic [4:0] OP_STD  = 5'b10110;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_IMM,
    S_INT
  } fetch_state_t;

  // True for opcodes whose encoding is followed by a 16-bit immediate word.
  function automatic logic has_imm(input logic [4:0] opcode);
    return (opcode == OP_IADD) || (opcode == OP_LDM) ||
           (opcode == OP_LDD)  || (opcode == OP_STD);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads 16-bit words from imem and
// hands decode either a one-word instruction or an opcode/immediate pair.
// Also performs the boot-vector load, branch redirect, stall and
// interrupt-vector entry.
module fetch_stage
  import isa_pkg::*;
#(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  INT_VEC   = ADDR_W'(1),
  parameter logic [15:0]        NOP_WORD  = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              irq,
  output logic [15:0]       instruction,
  output logic [15:0]       immediate,
  output logic              if_valid,
  output logic [ADDR_W-1:0] pc_next,
  output logic              int_ack,
  output logic [ADDR_W-1:0] ret_pc
);

  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [15:0]       held, held_d;
  logic              irq_pending, irq_pending_d;
  logic [15:0]       instruction_d, immediate_d;
  logic              if_valid_d, int_ack_d;
  logic [ADDR_W-1:0] pc_next_d, ret_pc_d;

  // PC arithmetic wraps naturally at 2^ADDR_W.
  assign pc_inc = pc + ADDR_W'(1);

  // Vector fetches use fixed addresses; everything else reads at the PC.
  always_comb begin
    imem_addr = pc;
    case (state)
      S_BOOT:  imem_addr = RESET_VEC;
      S_INT:   imem_addr = INT_VEC;
      default: imem_addr = pc;
    endcase
  end

  // Next-state and next-register values; defaults hold everything.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    held_d        = held;
    irq_pending_d = irq_pending | irq;
    instruction_d = instruction;
    immediate_d   = immediate;
    if_valid_d    = if_valid;
    int_ack_d     = int_ack;
    pc_next_d     = pc_next;
    ret_pc_d      = ret_pc;

    // Boot is never frozen so the core always leaves reset with a valid PC.
    if (!(stall && state != S_BOOT)) begin
      if_valid_d    = 1'b0;
      int_ack_d     = 1'b0;
      instruction_d = NOP_WORD;
      immediate_d   = 16'h0000;
      case (state)
        S_BOOT: begin
          pc_d    = imem_data[ADDR_W-1:0];
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (branch_taken) begin
            pc_d = branch_target;
          end else if (irq_pending) begin
            ret_pc_d = pc;
            state_d  = S_INT;
          end else if (has_imm(imem_data[15:11])) begin
            held_d  = imem_data;
            pc_d    = pc_inc;
            state_d = S_IMM;
          end else begin
            instruction_d = imem_data;
            if_valid_d    = 1'b1;
            pc_d          = pc_inc;
            pc_next_d     = pc_inc;
          end
        end
        S_IMM: begin
          // Interrupts wait here so a two-word instruction is never split.
          if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            instruction_d = held;
            immediate_d   = imem_data;
            if_valid_d    = 1'b1;
            pc_d          = pc_inc;
            pc_next_d     = pc_inc;
          end
          state_d = S_FETCH;
        end
        S_INT: begin
          pc_d          = imem_data[ADDR_W-1:0];
          int_ack_d     = 1'b1;
          irq_pending_d = 1'b0;
          state_d       = S_FETCH;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      pc          <= '0;
      held        <= 16'h0000;
      irq_pending <= 1'b0;
      instruction <= NOP_WORD;
      immediate   <= 16'h0000;
      if_valid    <= 1'b0;
      int_ack     <= 1'b0;
      pc_next     <= '0;
      ret_pc      <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      held        <= held_d;
      irq_pending <= irq_pending_d;
      instruction <= instruction_d;
      immediate   <= immediate_d;
      if_valid    <= if_valid_d;
      int_ack     <= int_ack_d;
      pc_next     <= pc_next_d;
      ret_pc      <= ret_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        irq;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic        if_valid;
  logic [15:0] pc_next;
  logic        int_ack;
  logic [15:0] ret_pc;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .irq           (irq),
    .instruction   (instruction),
    .immediate     (immediate),
    .if_valid      (if_valid),
    .pc_next       (pc_next),
    .int_ack       (int_ack),
    .ret_pc        (ret_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0010;  // boot vector; also immediate for the wrap case
    mem[16'h0001] = 16'h0200;  // interrupt vector
    mem[16'h0010] = 16'h1880;  // NOT
    mem[16'h0011] = 16'hA000;  // LDM
    mem[16'h0012] = 16'hBEEF;
    mem[16'h0013] = 16'h2222;
    mem[16'h0014] = 16'hA800;  // LDD
    mem[16'h0015] = 16'h1234;  // immediate dropped by the branch
    mem[16'h0040] = 16'h3333;
    mem[16'h0041] = 16'hB000;  // STD
    mem[16'h0042] = 16'h5555;
    mem[16'h0200] = 16'h4444;
    mem[16'hFFFF] = 16'h5800;  // IADD, immediate wraps to address 0

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; irq = 1'b0;
    step();
    step();
    check("rst_instr",   instruction, 16'h0000);
    check("rst_imm",     immediate,   16'h0000);
    check("rst_valid",   if_valid,    1'b0);
    check("rst_pc_next", pc_next,     16'h0000);
    check("rst_int_ack", int_ack,     1'b0);
    check("rst_ret_pc",  ret_pc,      16'h0000);
    check("rst_addr",    imem_addr,   16'h0000);

    // Boot, then a one-word NOT
    reset = 1'b0;
    step();
    check("boot_valid", if_valid,  1'b0);
    check("boot_addr",  imem_addr, 16'h0010);
    step();
    check("not_instr",   instruction, 16'h1880);
    check("not_valid",   if_valid,    1'b1);
    check("not_pc_next", pc_next,     16'h0011);

    // Two-word LDM with one bubble
    step();
    check("ldm_bubble", if_valid,  1'b0);
    check("ldm_addr",   imem_addr, 16'h0012);
    step();
    check("ldm_instr",   instruction, 16'hA000);
    check("ldm_imm",     immediate,   16'hBEEF);
    check("ldm_valid",   if_valid,    1'b1);
    check("ldm_pc_next", pc_next,     16'h0013);

    // Stall holds everything for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instruction, 16'hA000);
      check("stall_imm",   immediate,   16'hBEEF);
      check("stall_valid", if_valid,    1'b1);
      check("stall_addr",  imem_addr,   16'h0013);
    end
    stall = 1'b0;
    step();
    check("resume_instr",   instruction, 16'h2222);
    check("resume_imm",     immediate,   16'h0000);
    check("resume_pc_next", pc_next,     16'h0014);

    // Branch while in S_IMM drops the held LDD word
    step();
    check("ldd_bubble", if_valid, 1'b0);
    branch_taken = 1'b1; branch_target = 16'h0040;
    step();
    check("br_valid", if_valid,    1'b0);
    check("br_instr", instruction, 16'h0000);
    check("br_addr",  imem_addr,   16'h0040);
    branch_taken = 1'b0;
    step();
    check("br_tgt_instr",   instruction, 16'h3333);
    check("br_tgt_valid",   if_valid,    1'b1);
    check("br_tgt_pc_next", pc_next,     16'h0041);

    // irq pulse in S_IMM: STD completes first, then vector entry
    step();
    check("std_bubble", if_valid, 1'b0);
    irq = 1'b1;
    step();
    irq = 1'b0;
    check("std_instr",   instruction, 16'hB000);
    check("std_imm",     immediate,   16'h5555);
    check("std_valid",   if_valid,    1'b1);
    check("std_pc_next", pc_next,     16'h0043);
    check("std_no_ack",  int_ack,     1'b0);
    step();
    check("int_bubble", if_valid,  1'b0);
    check("int_noack",  int_ack,   1'b0);
    check("int_ret_pc", ret_pc,    16'h0043);
    check("int_addr",   imem_addr, 16'h0001);
    step();
    check("int_ack",      int_ack,   1'b1);
    check("int_vec_addr", imem_addr, 16'h0200);
    step();
    check("int_ack_once", int_ack,     1'b0);
    check("isr_instr",    instruction, 16'h4444);
    check("isr_pc_next",  pc_next,     16'h0201);

    // Two-word instruction at 0xFFFF wraps its immediate to 0x0000
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    check("wrap_br_addr", imem_addr, 16'hFFFF);
    step();
    check("wrap_bubble", if_valid,  1'b0);
    check("wrap_addr",   imem_addr, 16'h0000);
    step();
    check("wrap_instr",   instruction, 16'h5800);
    check("wrap_imm",     immediate,   16'h0010);
    check("wrap_pc_next", pc_next,     16'h0001);

    // Reset mid-stream, then boot proceeds despite stall
    reset = 1'b1;
    step();
    check("rst2_valid",   if_valid,    1'b0);
    check("rst2_instr",   instruction, 16'h0000);
    check("rst2_pc_next", pc_next,     16'h0000);
    check("rst2_addr",    imem_addr,   16'h0000);
    reset = 1'b0; stall = 1'b1;
    step();
    check("boot_nostall_addr", imem_addr, 16'h0010);
    stall = 1'b0;
    step();
    check("reboot_instr", instruction, 16'h1880);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
